// File: rtl/pb_pkg.sv
// Shared types for the push-button conditioner.
// Holds the debounce FSM state encoding and the press counter width.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } pb_state_t;

    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
// Both stages clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pb_conditioner.sv
// Push-button conditioner: synchronizes, debounces, emits edge pulses
// and counts accepted presses.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   PB_in,
    input  logic                   clr_cnt,
    output logic                   pb_level,
    output logic                   pb_rise,
    output logic                   pb_fall,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic                   w_sync;
    pb_state_t              r_state;
    pb_state_t              w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_rise;
    logic                   w_fall;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [PRESS_CNT_W-1:0] r_press;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (PB_in),
        .q     (w_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter holds the number of consecutive samples that disagree with the level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        unique case (r_state)
            IDLE_LO: begin
                if (w_sync) begin
                    w_state_nxt = CHK_HI;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            CHK_HI: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = IDLE_HI;
                    w_cnt_nxt   = '0;
                    w_rise      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            IDLE_HI: begin
                if (!w_sync) begin
                    w_state_nxt = CHK_LO;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            CHK_LO: begin
                if (w_sync) begin
                    w_state_nxt = IDLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = '0;
                    w_fall      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_press <= '0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
            if (w_rise) begin
                r_level <= 1'b1;
            end else if (w_fall) begin
                r_level <= 1'b0;
            end
            if (clr_cnt) begin
                r_press <= '0;
            end else if (w_rise) begin
                r_press <= r_press + PRESS_CNT_W'(1);
            end
        end
    end

    assign pb_level  = r_level;
    assign pb_rise   = r_rise;
    assign pb_fall   = r_fall;
    assign press_cnt = r_press;

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed latency/bounce/wrap/reset cases
// plus random bouncing input compared against a run-length model.
module tb_pb_conditioner;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       PB_in = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       pb_level;
    logic       pb_rise;
    logic       pb_fall;
    logic [7:0] press_cnt;

    int errors = 0;
    int checks = 0;
    int n_rise = 0;
    int n_fall = 0;

    pb_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PB_in     (PB_in),
        .clr_cnt   (clr_cnt),
        .pb_level  (pb_level),
        .pb_rise   (pb_rise),
        .pb_fall   (pb_fall),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    // Model: PB_in reaches the debouncer two edges late; a level change
    // is accepted once N consecutive samples disagree with the level.
    bit         q_pb[$];
    bit         m_level;
    bit         m_rise;
    bit         m_fall;
    int         m_streak;
    logic [7:0] m_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q_pb.delete();
        q_pb.push_back(1'b0);
        q_pb.push_back(1'b0);
        m_level  = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_streak = 0;
        m_cnt    = 8'd0;
    endfunction

    function automatic void model_step();
        bit s;
        s = q_pb.pop_front();
        q_pb.push_back(PB_in);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) m_streak++;
        else m_streak = 0;
        if (m_streak == N) begin
            m_level  = !m_level;
            m_streak = 0;
            if (m_level) m_rise = 1'b1;
            else m_fall = 1'b1;
        end
        if (clr_cnt) m_cnt = 8'd0;
        else if (m_rise) m_cnt = m_cnt + 8'd1;
    endfunction

    initial begin : monitor
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            chk("mdl_level", pb_level, m_level);
            chk("mdl_rise", pb_rise, m_rise);
            chk("mdl_fall", pb_fall, m_fall);
            chk("mdl_cnt", press_cnt, m_cnt);
            if (pb_rise) n_rise++;
            if (pb_fall) n_fall++;
        end
    end

    // Edge index (0 = first edge after call) of first pulse, and pulse width.
    task automatic count_to_pulse(input bit want_rise, output int k, output int np);
        logic p;
        k  = -1;
        np = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            p = want_rise ? pb_rise : pb_fall;
            if (p) begin
                np++;
                if (k < 0) k = i;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_once();
        @(negedge clk);
        PB_in = 1'b1;
        repeat (8) @(negedge clk);
        PB_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin : stim
        int k;
        int np;
        int r0;
        int f0;
        int hold;

        repeat (2) @(negedge clk);
        chk("reset_level", pb_level, 0);
        chk("reset_cnt", press_cnt, 0);
        rst_n = 1'b1;

        @(negedge clk);
        PB_in = 1'b1;
        count_to_pulse(1'b1, k, np);
        chk("press_rise_edge", k, 5);
        chk("press_rise_width", np, 1);
        chk("press_level", pb_level, 1);
        chk("press_cnt1", press_cnt, 1);

        @(negedge clk);
        PB_in = 1'b0;
        count_to_pulse(1'b0, k, np);
        chk("release_fall_edge", k, 5);
        chk("release_fall_width", np, 1);
        chk("release_level", pb_level, 0);
        chk("release_cnt", press_cnt, 1);

        r0 = n_rise;
        f0 = n_fall;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            PB_in = 1'b1;
            @(negedge clk);
            @(negedge clk);
            PB_in = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("bounce_rises", n_rise - r0, 0);
        chk("bounce_falls", n_fall - f0, 0);
        chk("bounce_level", pb_level, 0);

        @(negedge clk);
        PB_in = 1'b1;
        count_to_pulse(1'b1, k, np);
        chk("post_bounce_edge", k, 5);
        chk("post_bounce_cnt", press_cnt, 2);
        @(negedge clk);
        PB_in = 1'b0;
        count_to_pulse(1'b0, k, np);

        do_reset();
        for (int p = 0; p < 256; p++) begin
            press_once();
            if (p == 254) chk("wrap_cnt255", press_cnt, 255);
        end
        chk("wrap_cnt0", press_cnt, 0);

        press_once();
        chk("clr_pre_cnt", press_cnt, 1);
        @(negedge clk);
        PB_in = 1'b1;
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_rise", pb_rise, 1);
        chk("clr_cnt_prio", press_cnt, 0);
        @(negedge clk);
        clr_cnt = 1'b0;
        PB_in   = 1'b0;
        repeat (10) @(negedge clk);

        press_once();
        chk("rst_pre_cnt", press_cnt, 1);
        @(negedge clk);
        PB_in = 1'b1;
        for (int i = 0; i < 4; i++) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_cnt", press_cnt, 0);
        chk("midrst_level", pb_level, 0);
        chk("midrst_rise", pb_rise, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_to_pulse(1'b1, k, np);
        chk("midrst_rise_edge", k, 5);
        chk("midrst_rise_width", np, 1);

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                PB_in = 1'($urandom_range(0, 1));
                hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 4);
            end
            hold--;
            clr_cnt = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable synchronized samples required to accept a level change (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port PB_in  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-005 SHALL have port clr_cnt  input  1  synchronous clear of press_cnt.
REQ-006 SHALL have port pb_level  output  1  debounced registered button level.
REQ-007 SHALL have port pb_rise  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-008 SHALL have port pb_fall  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-009 SHALL have port press_cnt  output  8  count of accepted presses.

Function
REQ-010 SHALL pass PB_in through a two-flop synchronizer; only the second flop output (sync) SHALL feed further logic.
REQ-011 SHALL implement FSM states IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
REQ-012 SHALL use a debounce counter of width clog2(DEBOUNCE_CYCLES), counting consecutive sync samples that differ from pb_level.
REQ-013 IDLE_LO: sync=1 -> CHK_HI, cnt=1; else hold, cnt=0.
REQ-014 CHK_HI: sync=0 -> IDLE_LO, cnt=0; sync=1 and cnt=DEBOUNCE_CYCLES-1 -> IDLE_HI, pb_level=1, pb_rise=1, cnt=0; else cnt+1.
REQ-015 IDLE_HI and CHK_LO SHALL mirror REQ-013/014 with levels inverted, producing pb_level=0 and pb_fall=1.
REQ-016 Latency: with PB_in stable from clock edge E0, pb_level/pb_rise SHALL change at edge E0+1+DEBOUNCE_CYCLES (2-flop sync plus DEBOUNCE_CYCLES samples).
REQ-017 Any bounce (sync returning to pb_level) before acceptance SHALL abort the check with no pulse and restart counting from the next differing sample.
REQ-018 pb_rise and pb_fall SHALL be registered, high for exactly one cycle per accepted change, and never simultaneously high.
REQ-019 press_cnt SHALL increment on pb_rise and wrap 255 -> 0.
REQ-020 clr_cnt SHALL have priority over increment: clr_cnt=1 with pb_rise=1 SHALL give press_cnt=0.
REQ-021 pb_level SHALL only change in the same cycle as its corresponding pulse.

Reset
REQ-022 rst_n low SHALL asynchronously force both sync flops=0, state=IDLE_LO, cnt=0, pb_level=0, pb_rise=0, pb_fall=0, press_cnt=0.
REQ-023 Reset asserted mid-check SHALL discard the partial count; no pulse SHALL issue on release.
REQ-024 After rst_n deasserts, PB_in held high SHALL be treated as a new press (pb_rise after REQ-016 latency).

Structure
REQ-025 FSM state enum and the 8-bit press_cnt width constant SHALL live in the shared package pb_pkg.
REQ-026 The synchronizer SHALL be a separate sub-module sync2 (clk, rst_n, d, q), reset value 0; FSM, counters and outputs stay in pb_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset, PB_in=1 stable from edge 0 -> pb_level and one-cycle pb_rise at edge 5, press_cnt=1.
REQ-028 PB_in toggled high 2 cycles, low 1 cycle, repeated 5 times -> no pulse, pb_level stays 0, state returns to IDLE_LO.
REQ-029 Accepted press then PB_in=0 stable -> pb_fall one cycle at edge 5 after the falling edge, press_cnt unchanged.
REQ-030 256 clean presses -> press_cnt reads 0 after the 256th; clr_cnt coincident with pb_rise -> press_cnt=0.
REQ-031 rst_n pulsed low while in CHK_HI with cnt=2 -> all outputs 0 immediately; no pulse before PB_in re-stabilizes for 5 edges.
